// File: rtl/ex_muldiv_stage.sv
// Multi-cycle RV32M/RV64M multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide share one 2*XLEN accumulator; latency is fixed at XLEN+2 cycles.
module ex_muldiv_stage #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int SELW    = $clog2(NUM_FWD + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    md_enable_ip,
  input  logic [2:0]              md_operator_ip,
  input  logic [XLEN-1:0]         operand_a_ip,
  input  logic [XLEN-1:0]         operand_b_ip,
  input  logic [SELW-1:0]         fa_sel_ip,
  input  logic [SELW-1:0]         fb_sel_ip,
  input  logic [NUM_FWD*XLEN-1:0] fw_data_ip,
  input  logic [4:0]              write_reg_addr_ip,
  input  logic                    flush_ip,
  output logic                    busy_op,
  output logic [XLEN-1:0]         result_op,
  output logic                    result_valid_op,
  output logic [4:0]              write_reg_addr_op
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_magB;
  logic [XLEN-1:0]     r_opA;
  logic [2:0]          r_op;
  logic [4:0]          r_rd;
  logic                r_negQ;
  logic                r_negR;
  logic                r_divZero;
  logic                r_ovf;

  logic [XLEN-1:0]     w_opA;
  logic [XLEN-1:0]     w_opB;
  logic                w_signA;
  logic                w_signB;
  logic [XLEN-1:0]     w_magA;
  logic [XLEN-1:0]     w_magB;
  logic                w_accept;
  logic [XLEN:0]       w_addend;
  logic [XLEN:0]       w_mulSum;
  logic [XLEN:0]       w_shift;
  logic                w_ge;
  logic [XLEN-1:0]     w_diff;
  logic [2*XLEN-1:0]   w_accNext;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_quo;
  logic [XLEN-1:0]     w_rem;
  logic [XLEN-1:0]     w_result;

  // Select value 0, or anything above NUM_FWD, falls back to the decode operand.
  always_comb begin
    w_opA = operand_a_ip;
    w_opB = operand_b_ip;
    for (int k = 1; k <= NUM_FWD; k++) begin
      if (fa_sel_ip == SELW'(k)) w_opA = fw_data_ip[(k-1)*XLEN +: XLEN];
      if (fb_sel_ip == SELW'(k)) w_opB = fw_data_ip[(k-1)*XLEN +: XLEN];
    end
  end

  always_comb begin
    w_signA  = (md_operator_ip inside {3'd1, 3'd2, 3'd4, 3'd6}) & w_opA[XLEN-1];
    w_signB  = (md_operator_ip inside {3'd1, 3'd4, 3'd6}) & w_opB[XLEN-1];
    w_magA   = w_signA ? -w_opA : w_opA;
    w_magB   = w_signB ? -w_opB : w_opB;
    w_accept = (r_state == IDLE) && md_enable_ip && !flush_ip;
    busy_op  = w_accept || ((r_state == RUN) && !flush_ip);
  end

  // Multiply keeps {partial product, remaining multiplier}; divide keeps {remainder, quotient bits}.
  always_comb begin
    w_addend = r_acc[0] ? {1'b0, r_magB} : '0;
    w_mulSum = {1'b0, r_acc[2*XLEN-1:XLEN]} + w_addend;
    w_shift  = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    w_ge     = w_shift >= {1'b0, r_magB};
    w_diff   = w_shift[XLEN-1:0] - r_magB;
    if (r_op[2]) begin
      w_accNext = {(w_ge ? w_diff : w_shift[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};
    end else begin
      w_accNext = {w_mulSum, r_acc[XLEN-1:1]};
    end
    w_prod = r_negQ ? -w_accNext : w_accNext;
    w_quo  = w_accNext[XLEN-1:0];
    w_rem  = w_accNext[2*XLEN-1:XLEN];
  end

  always_comb begin
    w_result = '0;
    if (!r_op[2]) begin
      w_result = (r_op[1:0] == 2'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    end else if (r_divZero) begin
      w_result = r_op[1] ? r_opA : '1;
    end else if (r_ovf) begin
      w_result = r_op[1] ? '0 : MIN_NEG;
    end else if (r_op[1]) begin
      w_result = r_negR ? -w_rem : w_rem;
    end else begin
      w_result = r_negQ ? -w_quo : w_quo;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state           <= IDLE;
      r_cnt             <= '0;
      r_acc             <= '0;
      r_magB            <= '0;
      r_opA             <= '0;
      r_op              <= '0;
      r_rd              <= '0;
      r_negQ            <= 1'b0;
      r_negR            <= 1'b0;
      r_divZero         <= 1'b0;
      r_ovf             <= 1'b0;
      result_op         <= '0;
      result_valid_op   <= 1'b0;
      write_reg_addr_op <= '0;
    end else begin
      result_valid_op <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state   <= RUN;
            r_cnt     <= '0;
            r_acc     <= {{XLEN{1'b0}}, w_magA};
            r_magB    <= w_magB;
            r_opA     <= w_opA;
            r_op      <= md_operator_ip;
            r_rd      <= write_reg_addr_ip;
            r_negQ    <= w_signA ^ w_signB;
            r_negR    <= w_signA;
            r_divZero <= (w_opB == '0);
            r_ovf     <= (md_operator_ip inside {3'd4, 3'd6}) && (w_opA == MIN_NEG) && (w_opB == '1);
          end
        end
        RUN: begin
          if (flush_ip) begin
            r_state <= IDLE;
          end else begin
            r_acc <= w_accNext;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST) begin
              r_state           <= DONE;
              result_op         <= w_result;
              result_valid_op   <= 1'b1;
              write_reg_addr_op <= r_rd;
            end
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Self-checking bench for ex_muldiv_stage: directed M-extension vectors against an arithmetic reference model.
// A per-cycle compare process checks every output; literal expectations pin the reference.
module tb_ex_muldiv_stage;

  localparam int XLEN    = 32;
  localparam int NUM_FWD = 2;
  localparam int SELW    = 2;

  logic                    clock = 1'b0;
  logic                    reset = 1'b1;
  logic                    md_enable_ip = 1'b0;
  logic [2:0]              md_operator_ip = '0;
  logic [XLEN-1:0]         operand_a_ip = '0;
  logic [XLEN-1:0]         operand_b_ip = '0;
  logic [SELW-1:0]         fa_sel_ip = '0;
  logic [SELW-1:0]         fb_sel_ip = '0;
  logic [NUM_FWD*XLEN-1:0] fw_data_ip = '0;
  logic [4:0]              write_reg_addr_ip = '0;
  logic                    flush_ip = 1'b0;
  logic                    busy_op;
  logic [XLEN-1:0]         result_op;
  logic                    result_valid_op;
  logic [4:0]              write_reg_addr_op;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  int          cyc = 0;
  int          prevCyc;
  int          accCyc = 0;
  bit          inFlight = 1'b0;
  logic [31:0] pendRes = '0;
  logic [4:0]  pendRd = '0;
  logic [31:0] expRes = '0;
  logic [4:0]  expRd = '0;
  logic        expValid = 1'b0;
  logic        expBusy;

  ex_muldiv_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) dut (
    .clock             (clock),
    .reset             (reset),
    .md_enable_ip      (md_enable_ip),
    .md_operator_ip    (md_operator_ip),
    .operand_a_ip      (operand_a_ip),
    .operand_b_ip      (operand_b_ip),
    .fa_sel_ip         (fa_sel_ip),
    .fb_sel_ip         (fb_sel_ip),
    .fw_data_ip        (fw_data_ip),
    .write_reg_addr_ip (write_reg_addr_ip),
    .flush_ip          (flush_ip),
    .busy_op           (busy_op),
    .result_op         (result_op),
    .result_valid_op   (result_valid_op),
    .write_reg_addr_op (write_reg_addr_op)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pickFwd(input logic [1:0] sel, input logic [31:0] op,
                                          input logic [63:0] fw);
    case (sel)
      2'd1:    return fw[31:0];
      2'd2:    return fw[63:32];
      default: return op;
    endcase
  endfunction

  // Plain-arithmetic reference for the eight funct3 operations.
  function automatic logic [31:0] refResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, pu;
    bit              ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin pu = ua * ub; return pu[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin pu = ua * ub; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        pu = ua / ub; return pu[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        pu = ua % ub; return pu[31:0];
      end
    endcase
  endfunction

  // Timing model: accept in cycle N, strobe in cycle N+XLEN+1, flush or reset cancels.
  always @(posedge clock) begin
    prevCyc = cyc;
    cyc     = cyc + 1;
    if (reset) begin
      inFlight = 1'b0;
      expValid = 1'b0;
      expRes   = '0;
      expRd    = '0;
    end else begin
      expValid = 1'b0;
      if (!inFlight) begin
        if (md_enable_ip && !flush_ip) begin
          inFlight = 1'b1;
          accCyc   = prevCyc;
          pendRes  = refResult(md_operator_ip, pickFwd(fa_sel_ip, operand_a_ip, fw_data_ip),
                               pickFwd(fb_sel_ip, operand_b_ip, fw_data_ip));
          pendRd   = write_reg_addr_ip;
        end
      end else if (flush_ip) begin
        inFlight = 1'b0;
      end else if (prevCyc == accCyc + XLEN) begin
        expValid = 1'b1;
        expRes   = pendRes;
        expRd    = pendRd;
      end else if (prevCyc == accCyc + XLEN + 1) begin
        inFlight = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (checkEn) begin
      if (!inFlight) expBusy = md_enable_ip && !flush_ip;
      else if (cyc <= accCyc + XLEN) expBusy = !flush_ip;
      else expBusy = 1'b0;
      checkOutput("cyc_busy", {63'd0, busy_op}, {63'd0, expBusy});
      checkOutput("cyc_valid", {63'd0, result_valid_op}, {63'd0, expValid});
      checkOutput("cyc_result", {32'd0, result_op}, {32'd0, expRes});
      checkOutput("cyc_rd", {59'd0, write_reg_addr_op}, {59'd0, expRd});
    end
  end

  // Called just after a rising edge; returns just after the edge that ends the DONE cycle.
  task automatic applyStimulus(input string name, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [1:0] fa, input logic [1:0] fb,
                               input logic [63:0] fw, input logic [4:0] rd, input logic [31:0] lit);
    int waited;
    bit got;
    md_enable_ip      = 1'b1;
    md_operator_ip    = op;
    operand_a_ip      = a;
    operand_b_ip      = b;
    fa_sel_ip         = fa;
    fb_sel_ip         = fb;
    fw_data_ip        = fw;
    write_reg_addr_ip = rd;
    waited = 0;
    got    = 1'b0;
    while (!got && waited < XLEN + 8) begin
      @(negedge clock);
      waited++;
      if (result_valid_op) got = 1'b1;
      else if (waited == 2) begin
        operand_a_ip      = $urandom;
        operand_b_ip      = $urandom;
        fw_data_ip        = {$urandom, $urandom};
        fa_sel_ip         = 2'($urandom_range(0, 3));
        fb_sel_ip         = 2'($urandom_range(0, 3));
        write_reg_addr_ip = 5'($urandom_range(0, 31));
      end
    end
    checkOutput({name, "_latency"}, 64'(waited), 64'(XLEN + 2));
    checkOutput(name, {32'd0, result_op}, {32'd0, lit});
    checkOutput({name, "_rd"}, {59'd0, write_reg_addr_op}, {59'd0, rd});
    @(posedge clock);
    #1;
    md_enable_ip = 1'b0;
  endtask

  task automatic waitNoValid(input string name, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (result_valid_op) seen++;
    end
    checkOutput(name, 64'(seen), 64'd0);
  endtask

  initial begin
    int cnt;
    @(posedge clock);
    checkEn = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("reset_result", {32'd0, result_op}, 64'd0);
    checkOutput("reset_valid", {63'd0, result_valid_op}, 64'd0);
    checkOutput("reset_busy", {63'd0, busy_op}, 64'd0);
    @(posedge clock);
    #1;

    applyStimulus("mul_neg",      3'd0, 32'd7,         32'hFFFF_FFFD, 2'd0, 2'd0, 64'd0, 5'd1,  32'hFFFF_FFEB);
    applyStimulus("mulh_min",     3'd1, 32'h8000_0000, 32'h8000_0000, 2'd0, 2'd0, 64'd0, 5'd2,  32'h4000_0000);
    applyStimulus("mulhu_min",    3'd3, 32'h8000_0000, 32'h8000_0000, 2'd0, 2'd0, 64'd0, 5'd3,  32'h4000_0000);
    applyStimulus("mulhsu",       3'd2, 32'hFFFF_FFFF, 32'd2,         2'd0, 2'd0, 64'd0, 5'd4,  32'hFFFF_FFFF);
    applyStimulus("div_neg",      3'd4, 32'hFFFF_FFF9, 32'd2,         2'd0, 2'd0, 64'd0, 5'd5,  32'hFFFF_FFFD);
    applyStimulus("rem_neg",      3'd6, 32'hFFFF_FFF9, 32'd2,         2'd0, 2'd0, 64'd0, 5'd6,  32'hFFFF_FFFF);
    applyStimulus("rem_negdivsr", 3'd6, 32'd7,         32'hFFFF_FFFE, 2'd0, 2'd0, 64'd0, 5'd7,  32'd1);
    applyStimulus("divu",         3'd5, 32'd100,       32'd7,         2'd0, 2'd0, 64'd0, 5'd8,  32'd14);
    applyStimulus("remu",         3'd7, 32'd100,       32'd7,         2'd0, 2'd0, 64'd0, 5'd9,  32'd2);
    applyStimulus("divu_zero",    3'd5, 32'd5,         32'd0,         2'd0, 2'd0, 64'd0, 5'd10, 32'hFFFF_FFFF);
    applyStimulus("div_zero",     3'd4, 32'hFFFF_FFF0, 32'd0,         2'd0, 2'd0, 64'd0, 5'd11, 32'hFFFF_FFFF);
    applyStimulus("rem_zero",     3'd6, 32'd5,         32'd0,         2'd0, 2'd0, 64'd0, 5'd12, 32'd5);
    applyStimulus("div_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 2'd0, 2'd0, 64'd0, 5'd13, 32'h8000_0000);
    applyStimulus("rem_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 2'd0, 2'd0, 64'd0, 5'd14, 32'd0);
    applyStimulus("fwd_mul",      3'd0, 32'd0,         32'd0,         2'd2, 2'd1, {32'd3, 32'd4}, 5'd15, 32'd12);
    applyStimulus("fwd_oob",      3'd0, 32'd5,         32'd2,         2'd3, 2'd0, {32'd3, 32'd4}, 5'd16, 32'd10);

    // Squash in RUN cycle 10: no strobe, previous result and destination held.
    md_enable_ip      = 1'b1;
    md_operator_ip    = 3'd0;
    operand_a_ip      = 32'd9;
    operand_b_ip      = 32'd9;
    fa_sel_ip         = 2'd0;
    fb_sel_ip         = 2'd0;
    write_reg_addr_ip = 5'd20;
    repeat (10) @(posedge clock);
    #1;
    flush_ip     = 1'b1;
    md_enable_ip = 1'b0;
    @(negedge clock);
    checkOutput("flush_busy", {63'd0, busy_op}, 64'd0);
    @(posedge clock);
    #1;
    flush_ip = 1'b0;
    waitNoValid("flush_noValid", XLEN + 4);
    checkOutput("flush_resHeld", {32'd0, result_op}, 64'd10);
    checkOutput("flush_rdHeld", {59'd0, write_reg_addr_op}, 64'd16);

    // Enable and flush together in IDLE: nothing is accepted.
    @(posedge clock);
    #1;
    md_enable_ip = 1'b1;
    flush_ip     = 1'b1;
    @(negedge clock);
    checkOutput("simul_busy", {63'd0, busy_op}, 64'd0);
    @(posedge clock);
    #1;
    md_enable_ip = 1'b0;
    flush_ip     = 1'b0;
    @(negedge clock);
    checkOutput("simul_notAccepted", {63'd0, busy_op}, 64'd0);
    waitNoValid("simul_noValid", 4);

    // Reset during RUN clears everything and suppresses the strobe.
    @(posedge clock);
    #1;
    md_enable_ip   = 1'b1;
    md_operator_ip = 3'd5;
    operand_a_ip   = 32'd100;
    operand_b_ip   = 32'd7;
    write_reg_addr_ip = 5'd3;
    repeat (6) @(posedge clock);
    #1;
    reset        = 1'b1;
    md_enable_ip = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("rst_result", {32'd0, result_op}, 64'd0);
    checkOutput("rst_rd", {59'd0, write_reg_addr_op}, 64'd0);
    checkOutput("rst_busy", {63'd0, busy_op}, 64'd0);
    cnt = 0;
    for (int i = 0; i < XLEN + 4; i++) begin
      @(negedge clock);
      if (result_valid_op) cnt++;
    end
    checkOutput("rst_noValid", 64'(cnt), 64'd0);
    @(posedge clock);
    #1;
    applyStimulus("after_rst",    3'd0, 32'd3,         32'd4,         2'd0, 2'd0, 64'd0, 5'd21, 32'd12);

    repeat (2) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ex_muldiv_stage.md
# ex_muldiv_stage

Parametrised multi-cycle execute unit for the RV32M/RV64M multiply/divide instructions. It sits beside the single-cycle ALU path in the execute stage. It applies the same forwarding selection to its operands, generalised to NUM_FWD bypass sources. While an operation iterates it stalls the front end. The result is delivered as a one-cycle registered pulse toward the EX/MEM buffer.

## Interface
Parameters:
- XLEN, 32: operand and result width; must be even and ≥ 8.
- NUM_FWD, 2: number of forwarding sources.
- SELW, $clog2(NUM_FWD+1): width of the forward select fields.

Ports:
- clock  in  1  rising-edge clock. This block uses one clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high.
- md_enable_ip  in  1  M-extension instruction present in EX.
- md_operator_ip  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- operand_a_ip, operand_b_ip  in  XLEN  register-file operands from decode.
- fa_sel_ip, fb_sel_ip  in  SELW  forward select. 0 selects the decode operand; k (1..NUM_FWD) selects fw_data_ip slice k-1; any other value is treated as 0.
- fw_data_ip  in  NUM_FWD*XLEN  forwarding sources; slice k occupies bits [k*XLEN +: XLEN].
- write_reg_addr_ip  in  5  destination register.
- flush_ip  in  1  squash request from the flush controller.
- busy_op  out  1  stall request to fetch/decode (combinational).
- result_op  out  XLEN  result (registered).
- result_valid_op  out  1  one-cycle result strobe (registered).
- write_reg_addr_op  out  5  destination register for the result (registered).

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE → RUN** when md_enable_ip=1 and flush_ip=0. At this accept edge the block latches:
  - the forwarded operands;
  - the operator;
  - write_reg_addr_ip;
  - the operand signs (MULH, DIV and REM use both signs; MULHSU uses only operand A's sign);
  - the operand magnitudes;
  - iteration counter = 0.
- **RUN**: one iteration per cycle. After XLEN iterations (counter reaches XLEN-1) the FSM goes to DONE, and the final result is written to result_op at that same edge.
- **DONE**: result_valid_op=1 for this one cycle. md_enable_ip is ignored here, because it is still the same held instruction. The FSM goes to IDLE on the next edge.
- Multiply: radix-2 shift-add on the magnitudes into a 2·XLEN product.
  - The product is two's-complement negated if the effective signs differ.
  - MUL returns the low XLEN bits. MULH, MULHSU and MULHU return the high XLEN bits.
- Divide: restoring division on the magnitudes.
  - Quotient is negated if sign(a) ≠ sign(b), for signed ops only.
  - Remainder takes the sign of the dividend.
- Special cases are detected at accept, but the result is still reported at the fixed latency:
  - Divide by zero: DIV/DIVU return all-ones; REM/REMU return operand A.
  - Signed overflow (DIV of the most-negative value by −1): DIV returns the most-negative value; REM returns 0.
- busy_op = (IDLE ∧ md_enable_ip ∧ ¬flush_ip) ∨ (RUN ∧ ¬flush_ip). busy_op is 0 in DONE so the held instruction advances.
- flush_ip in RUN or DONE: the FSM returns to IDLE at the next edge. result_valid_op is 0 in the following cycle and result_op is not updated.
- result_op and write_reg_addr_op hold their values until the next completed operation.

## Timing
- **Reset values**: state IDLE, result_op 0, result_valid_op 0, write_reg_addr_op 0, counter 0. busy_op evaluates to 0 while in IDLE with md_enable_ip=0.
- **Latency**: accept in cycle 0, then RUN for cycles 1..XLEN, then result_valid_op=1 in cycle XLEN+1. The latency is fixed for every operator and operand value.
- busy_op is high in cycles 0..XLEN and low in cycle XLEN+1.
- Back-to-back operations: the next instruction can be accepted in the cycle after DONE, so the minimum spacing between accepts is XLEN+2 cycles.
- Forward selects and operands are sampled only at the accept edge. Changes during RUN have no effect.
- Reset mid-operation: the FSM returns to IDLE at that edge, with no result strobe.
- Simultaneous flush_ip and md_enable_ip in IDLE: the instruction is not accepted and busy_op is 0.

## Test plan
- MUL with a=7, b=0xFFFFFFFD (XLEN=32), sel 0 → result_op=0xFFFFFFEB, result_valid_op high in cycle 33 only, busy_op high in cycles 0–32.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU same operands → 0x40000000; MULHSU with a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- Forwarding: fa_sel=2, fb_sel=1, slice1=3, slice0=4, operand inputs 0, MUL → 12. fa_sel=3 (out of range) with operand_a_ip=5 → operand 5 is used.
- Flush asserted in RUN cycle 10 → busy_op low in that cycle, IDLE next, no result_valid_op pulse, result_op unchanged. Reset asserted mid-RUN → same behaviour, and all outputs are 0.
